chart_recorder: RTL and testbench

Records a player-performed drum chart into the 100-slot, MSB-first song bit format that the note shifter plays back. One slot is one slow-clock beat. Sits beside the note shifter: the shifter reads a chart out slot by slot, and this block writes one in from the drum keys, slot by slot. The finished chart is then loaded into the shifter's song register in place of the hard-coded pattern.

---
 rtl/chart_recorder_if.sv | 28 ++
 rtl/chart_recorder.sv | 140 ++++++++++++++
 tb/tb_chart_recorder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chart_recorder_if.sv
// Bundle of the drum-chart recorder's control pulses and chart/status outputs.
// start, clear and tick are single-cycle pulses sampled on clock; hit is a raw asynchronous level.
interface chart_recorder_if #(
  parameter int SLOTS  = 100,
  parameter int WINDOW = 10,
  parameter int IDX_W  = 7
);
  logic              tick;
  logic              hit;
  logic              start;
  logic              clear;
  logic [SLOTS-1:0]  chart;
  logic [WINDOW-1:0] window;
  logic [IDX_W-1:0]  slot_idx;
  logic              recording;
  logic              done;
  logic [1:0]        state;

  modport master (
    output tick, hit, start, clear,
    input  chart, window, slot_idx, recording, done, state
  );

  modport slave (
    input  tick, hit, start, clear,
    output chart, window, slot_idx, recording, done, state
  );
endinterface

// File: rtl/chart_recorder.sv
// Records drum presses into an MSB-first slot chart, one slot per tick, for later
// loading into the note shifter's song register.
module chart_recorder #(
  parameter int SLOTS  = 100,
  parameter int WINDOW = 10,
  parameter int IDX_W  = 7
) (
  input  logic           clock,
  input  logic           resetn,
  chart_recorder_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_RECORD = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

  logic             hit_s1;
  logic             hit_s2;
  logic             hit_d;
  logic             hit_edge;

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [SLOTS-1:0] chart_q;
  logic [SLOTS-1:0] chart_n;
  logic [IDX_W-1:0] slot_idx;
  logic [IDX_W-1:0] slot_idx_n;
  logic [IDX_W-1:0] wr_pos;
  logic             pending;
  logic             pending_n;
  logic             recording;
  logic             done;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hit_s1 <= 1'b0;
      hit_s2 <= 1'b0;
      hit_d  <= 1'b0;
    end else begin
      hit_s1 <= bus.hit;
      hit_s2 <= hit_s1;
      hit_d  <= hit_s2;
    end
  end

  assign hit_edge = hit_s2 & ~hit_d;

  // Slot 0 lives in the MSB, so the open slot maps to bit SLOTS-1-slot_idx.
  assign wr_pos = LAST_IDX - slot_idx;

  always_comb begin
    state_n    = state;
    chart_n    = chart_q;
    slot_idx_n = slot_idx;
    pending_n  = pending;

    if (bus.clear) begin
      state_n    = S_IDLE;
      chart_n    = '0;
      slot_idx_n = '0;
      pending_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          pending_n = 1'b0;
          if (bus.start) begin
            chart_n    = '0;
            slot_idx_n = '0;
            state_n    = S_ARMED;
          end
        end
        S_ARMED: begin
          pending_n = 1'b0;
          if (bus.tick) begin
            slot_idx_n = '0;
            state_n    = S_RECORD;
          end
        end
        S_RECORD: begin
          if (bus.tick) begin
            // An edge arriving together with the tick belongs to the closing slot.
            chart_n[wr_pos] = pending | hit_edge;
            pending_n       = 1'b0;
            if (slot_idx == LAST_IDX) begin
              state_n = S_DONE;
            end else begin
              slot_idx_n = slot_idx + 1'b1;
            end
          end else if (hit_edge) begin
            pending_n = 1'b1;
          end
        end
        S_DONE: begin
          pending_n = 1'b0;
          if (bus.start) begin
            chart_n    = '0;
            slot_idx_n = '0;
            state_n    = S_ARMED;
          end
        end
        default: begin
          state_n    = S_IDLE;
          chart_n    = '0;
          slot_idx_n = '0;
          pending_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      chart_q   <= '0;
      slot_idx  <= '0;
      pending   <= 1'b0;
      recording <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      chart_q   <= chart_n;
      slot_idx  <= slot_idx_n;
      pending   <= pending_n;
      recording <= (state_n == S_RECORD);
      done      <= (state_n == S_DONE);
    end
  end

  assign bus.chart     = chart_q;
  assign bus.window    = chart_q[SLOTS-1 -: WINDOW];
  assign bus.slot_idx  = slot_idx;
  assign bus.recording = recording;
  assign bus.done      = done;
  assign bus.state     = state;

endmodule

// File: tb/tb_chart_recorder.sv
// Directed bench for chart_recorder: full record, held key, bounce, tick coincidence,
// ignored inputs, clear priority and asynchronous reset.
module tb_chart_recorder;

  localparam int SLOTS  = 100;
  localparam int WINDOW = 10;
  localparam int IDX_W  = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_RECORD = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [SLOTS-1:0]  exp_chart;
  logic [WINDOW-1:0] exp_window;

  chart_recorder_if #(.SLOTS(SLOTS), .WINDOW(WINDOW), .IDX_W(IDX_W)) bus ();

  chart_recorder #(.SLOTS(SLOTS), .WINDOW(WINDOW), .IDX_W(IDX_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
  endtask

  task automatic press();
    bus.hit = 1'b1;
    step(2);
    bus.hit = 1'b0;
    step(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_chart"},     bus.chart,     '0);
    check({tag, "_window"},    bus.window,    '0);
    check({tag, "_slot_idx"},  bus.slot_idx,  '0);
    check({tag, "_recording"}, bus.recording, 1'b0);
    check({tag, "_done"},      bus.done,      1'b0);
    check({tag, "_state"},     bus.state,     ST_IDLE);
  endtask

  // start, arming tick, then one slot per loop pass; even or odd slots get a press.
  task automatic full_record(input bit odd_slots);
    pulse_start();
    check("full_armed", bus.state, ST_ARMED);
    do_tick();
    check("full_rec_on", bus.recording, 1'b1);
    check("full_idx0", bus.slot_idx, 0);
    for (int s = 0; s < SLOTS; s++) begin
      if ((s % 2 == 1) == odd_slots) press();
      else step(2);
      step(1);
      if (s == SLOTS - 1) check("full_not_done_early", bus.done, 1'b0);
      do_tick();
    end
    check("full_done", bus.done, 1'b1);
    check("full_rec_off", bus.recording, 1'b0);
    check("full_state", bus.state, ST_DONE);
    check("full_idx_last", bus.slot_idx, SLOTS - 1);
  endtask

  initial begin
    bus.tick  = 1'b0;
    bus.hit   = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;

    // Reset state, during and after reset.
    step(2);
    check_all_zero("rst_in");
    resetn = 1'b1;
    step(1);
    check_all_zero("rst_out");

    // Basic record: presses in even slots.
    full_record(1'b0);
    exp_chart  = {50{2'b10}};
    exp_window = 10'b1010101010;
    check("basic_chart", bus.chart, exp_chart);
    check("basic_window", bus.window, exp_window);

    // start from DONE rezeroes; hit in ARMED is ignored; start mid-record is ignored.
    pulse_start();
    check("rearm_chart", bus.chart, '0);
    check("rearm_state", bus.state, ST_ARMED);
    check("rearm_done", bus.done, 1'b0);
    press();
    do_tick();
    step(3);
    do_tick();
    check("armed_hit_ignored", bus.chart[99], 1'b0);
    step(3);
    do_tick();
    step(3);
    do_tick();
    pulse_start();
    check("start_mid_state", bus.state, ST_RECORD);
    check("start_mid_rec", bus.recording, 1'b1);
    check("start_mid_idx", bus.slot_idx, 3);
    press();
    step(1);
    do_tick();
    check("after_start_slot3", bus.chart[96], 1'b1);
    check("after_start_idx", bus.slot_idx, 4);
    for (int s = 4; s < 40; s++) begin
      step(2);
      do_tick();
    end
    check("pre_clear_idx", bus.slot_idx, 40);

    // clear together with a tick at slot 40.
    bus.clear = 1'b1;
    bus.tick  = 1'b1;
    step(1);
    bus.clear = 1'b0;
    bus.tick  = 1'b0;
    check_all_zero("clear");
    do_tick();
    check("idle_tick_state", bus.state, ST_IDLE);
    check("idle_tick_idx", bus.slot_idx, 0);

    // Held key across three ticks, then four bounces in slot 5.
    pulse_start();
    do_tick();
    bus.hit = 1'b1;
    step(3);
    do_tick();
    step(3);
    do_tick();
    step(3);
    do_tick();
    bus.hit = 1'b0;
    step(3);
    do_tick();
    step(3);
    do_tick();
    repeat (4) press();
    step(1);
    do_tick();
    check("held_c99", bus.chart[99], 1'b1);
    check("held_c98", bus.chart[98], 1'b0);
    check("held_c97", bus.chart[97], 1'b0);
    check("bounce_c94", bus.chart[94], 1'b1);
    check("held_bounce_top6", bus.chart[99:94], 6'b100001);
    check("held_bounce_idx", bus.slot_idx, 6);
    pulse_clear();

    // Raw hit two cycles before the tick lands in the closing slot; one cycle before, in the next.
    pulse_start();
    do_tick();
    repeat (3) begin
      step(2);
      do_tick();
    end
    step(3);
    bus.hit = 1'b1;
    step(2);
    do_tick();
    check("coin_c96", bus.chart[96], 1'b1);
    check("coin_idx", bus.slot_idx, 4);
    step(1);
    bus.hit = 1'b0;
    step(3);
    do_tick();
    check("coin_c95", bus.chart[95], 1'b0);
    step(3);
    bus.hit = 1'b1;
    step(1);
    do_tick();
    step(1);
    bus.hit = 1'b0;
    step(3);
    do_tick();
    check("late_c94", bus.chart[94], 1'b0);
    check("late_c93", bus.chart[93], 1'b1);
    pulse_clear();

    // Asynchronous reset mid-record at slot 60.
    pulse_start();
    do_tick();
    for (int s = 0; s < 60; s++) begin
      if (s % 3 == 0) press();
      else step(2);
      step(1);
      do_tick();
    end
    check("pre_rst_idx", bus.slot_idx, 60);
    check("pre_rst_c99", bus.chart[99], 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("async_rst");
    step(2);
    resetn = 1'b1;
    step(1);

    // After release, a full chart with presses in odd slots.
    full_record(1'b1);
    exp_chart  = {50{2'b01}};
    exp_window = 10'b0101010101;
    check("post_rst_chart", bus.chart, exp_chart);
    check("post_rst_window", bus.window, exp_window);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
